// File: rtl/dsp_be_drx_align.sv
// Word aligner ahead of dsp_be_bert: bit slip across consecutive words, manual or auto-hunt on seed_good.
// Optional macro DSP_BE_DRX_ALIGN_REV_EN adds i_cfg_rev (bit-reverse input words).
module dsp_be_drx_align #(
  parameter int WIDTH    = 64,
  parameter int SLIP_W   = $clog2(WIDTH),
  parameter int HUNT_CYC = 32,
  parameter int LOSS_CYC = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [WIDTH-1:0]  i_drx,
  input  logic              i_cfg_auto_en,
  input  logic [SLIP_W-1:0] i_cfg_slip,
  input  logic              i_seed_good,
`ifdef DSP_BE_DRX_ALIGN_REV_EN
  input  logic              i_cfg_rev,
`endif
  output logic [WIDTH-1:0]  o_drx,
  output logic [SLIP_W-1:0] o_slip,
  output logic              o_locked,
  output logic              o_hunt_wrap,
  output logic [15:0]       o_slip_cnt
);

  localparam int HCW = $clog2(HUNT_CYC);
  localparam int LCW = $clog2(LOSS_CYC + 1);
  localparam logic [HCW-1:0]    HUNT_LAST = HCW'(HUNT_CYC - 1);
  localparam logic [LCW-1:0]    LOSS_LAST = LCW'(LOSS_CYC - 1);
  localparam logic [SLIP_W-1:0] SLIP_MAX  = SLIP_W'(WIDTH - 1);

  typedef enum logic [1:0] {ST_MANUAL, ST_HUNT, ST_LOCKED} state_e;

  state_e              state_q, state_d;
  logic [WIDTH-1:0]    din, prev_q, drx_q, drx_d;
  logic [2*WIDTH-1:0]  cat;
  logic [SLIP_W-1:0]   slip_q, slip_d;
  logic [15:0]         slip_cnt_q, slip_cnt_d;
  logic                wrap_q, wrap_d, locked_q, locked_d;
  logic [HCW-1:0]      hunt_q, hunt_d;
  logic [LCW-1:0]      loss_q, loss_d;

`ifdef DSP_BE_DRX_ALIGN_REV_EN
  always_comb begin
    din = i_drx;
    if (i_cfg_rev)
      for (int b = 0; b < WIDTH; b++) din[b] = i_drx[WIDTH-1-b];
  end
`else
  assign din = i_drx;
`endif

  // Window spans the current and previous word; slip k takes bits k..k+WIDTH-1.
  assign cat   = {din, prev_q};
  assign drx_d = cat[slip_q +: WIDTH];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= ST_MANUAL;
      prev_q     <= '0;
      drx_q      <= '0;
      slip_q     <= '0;
      slip_cnt_q <= '0;
      wrap_q     <= 1'b0;
      locked_q   <= 1'b0;
      hunt_q     <= '0;
      loss_q     <= '0;
    end else begin
      state_q    <= state_d;
      prev_q     <= din;
      drx_q      <= drx_d;
      slip_q     <= slip_d;
      slip_cnt_q <= slip_cnt_d;
      wrap_q     <= wrap_d;
      locked_q   <= locked_d;
      hunt_q     <= hunt_d;
      loss_q     <= loss_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    slip_d     = slip_q;
    slip_cnt_d = slip_cnt_q;
    wrap_d     = wrap_q;
    hunt_d     = hunt_q;
    loss_d     = loss_q;
    case (state_q)
      ST_MANUAL: begin
        if (i_cfg_auto_en) begin
          state_d    = ST_HUNT;
          hunt_d     = '0;
          slip_cnt_d = '0;
          wrap_d     = 1'b0;
        end else begin
          slip_d = i_cfg_slip;
        end
      end
      ST_HUNT: begin
        if (hunt_q == HUNT_LAST) begin
          hunt_d = '0;
          if (i_seed_good) begin
            state_d = ST_LOCKED;
            loss_d  = '0;
          end else begin
            slip_d = (slip_q == SLIP_MAX) ? '0 : slip_q + 1'b1;
            if (slip_q == SLIP_MAX) wrap_d = 1'b1;
            if (slip_cnt_q != 16'hFFFF) slip_cnt_d = slip_cnt_q + 16'd1;
          end
        end else begin
          hunt_d = hunt_q + 1'b1;
        end
      end
      ST_LOCKED: begin
        if (i_seed_good) begin
          loss_d = '0;
        end else if (loss_q == LOSS_LAST) begin
          state_d = ST_HUNT;
          loss_d  = '0;
          hunt_d  = '0;
        end else begin
          loss_d = loss_q + 1'b1;
        end
      end
      default: state_d = ST_MANUAL;
    endcase
    // Dropping auto-enable overrides everything and hands slip back to config.
    if (!i_cfg_auto_en) begin
      state_d = ST_MANUAL;
      slip_d  = i_cfg_slip;
    end
  end

  always_comb begin
    locked_d    = (state_d == ST_LOCKED);
    o_drx       = drx_q;
    o_slip      = slip_q;
    o_locked    = locked_q;
    o_hunt_wrap = wrap_q;
    o_slip_cnt  = slip_cnt_q;
  end

endmodule
